// File: rtl/radix_bist_analyzer_pkg.sv
// Shared BIST definitions: FSM states, default widths and the MISR step.
package radix_bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int              RESULT_W_DEF = 16;
  localparam logic [15:0]     POLY_DEF     = 16'h1021;

  // One MISR step: shift left, fold back the polynomial when the MSB falls
  // out, then mix in the new data word. Also used by the generator-side LFSR.
  function automatic logic [RESULT_W_DEF-1:0] misr_next(
    input logic [RESULT_W_DEF-1:0] sig,
    input logic [RESULT_W_DEF-1:0] din,
    input logic [RESULT_W_DEF-1:0] poly
  );
    return {sig[RESULT_W_DEF-2:0], 1'b0}
         ^ (sig[RESULT_W_DEF-1] ? poly : '0)
         ^ din;
  endfunction

endpackage

// File: rtl/radix_bist_analyzer_if.sv
// Multiplier completion interface: ready level plus the product word.
interface radix_bist_analyzer_if
  import radix_bist_pkg::*;
#(
  parameter int RESULT_W = RESULT_W_DEF
);
  logic                ready;
  logic [RESULT_W-1:0] result;

  // Multiplier drives, analyzer consumes.
  modport master (output ready, output result);
  modport slave  (input  ready, input  result);
endinterface

// File: rtl/radix_bist_analyzer_misr16.sv
// 16-bit signature register with seed load and compaction enable.
module misr16
  import radix_bist_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hFFFF,
  parameter logic [15:0] POLY = POLY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [15:0] din_i,
  output logic [15:0] sig_o
);

  logic [15:0] sig_q;

  // Seed on reset or session open; otherwise compact one word when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= SEED;
    end else if (load_i) begin
      sig_q <= SEED;
    end else if (en_i) begin
      sig_q <= misr_next(sig_q, din_i, POLY);
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/radix_bist_analyzer.sv
// BIST response analyzer: compacts multiplier products into a MISR, counts
// them, guards against a stalled multiplier and reports pass/fail.
module radix_bist_analyzer
  import radix_bist_pkg::*;
#(
  parameter int                  RESULT_W    = RESULT_W_DEF,
  parameter int                  N_VECTORS   = 256,
  parameter logic [RESULT_W-1:0] SEED        = 16'hFFFF,
  parameter logic [RESULT_W-1:0] POLY        = POLY_DEF,
  parameter logic [RESULT_W-1:0] GOLDEN_SIG  = 16'h0000,
  parameter int                  TIMEOUT_CYC = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               test_start,
  radix_bist_analyzer_if.slave               mul_if,
  output logic                               busy,
  output logic                               done,
  output logic                               pass,
  output logic                               timeout,
  output logic [RESULT_W-1:0]                signature,
  output logic [$clog2(N_VECTORS+1)-1:0]     vec_count
);

  localparam int CNT_W = $clog2(N_VECTORS + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

  state_e             state_q, state_d;
  logic               ready_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WD_W-1:0]    wd_q;
  logic               done_q, pass_q, timeout_q;

  logic               rise_w;
  logic               open_w;
  logic               accept_w;
  logic               last_w;
  logic               wd_expire_w;

  // A product completes on the rising edge of ready only.
  assign rise_w      = mul_if.ready & ~ready_q;
  assign last_w      = (cnt_q == CNT_W'(N_VECTORS - 1));
  assign wd_expire_w = (wd_q == WD_W'(TIMEOUT_CYC - 1));

  // Track ready in every state so a level already high at session open is not an edge.
  always_ff @(posedge clk) begin
    if (reset) ready_q <= 1'b0;
    else       ready_q <= mul_if.ready;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic; starts are only honoured outside a running session.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (test_start) state_d = COLLECT;
      COLLECT: begin
        if (rise_w) begin
          if (last_w) state_d = COMPARE;
        end else if (wd_expire_w) begin
          state_d = DONE;
        end
      end
      COMPARE: state_d = DONE;
      DONE:    if (test_start) state_d = COLLECT;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy flag plus MISR load/enable strobes.
  always_comb begin
    busy     = 1'b0;
    open_w   = 1'b0;
    accept_w = 1'b0;
    case (state_q)
      IDLE:    open_w = test_start;
      COLLECT: begin
        busy     = 1'b1;
        accept_w = rise_w;
      end
      COMPARE: busy = 1'b1;
      DONE:    open_w = test_start;
      default: ;
    endcase
  end

  // Product counter, watchdog and registered verdict flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      wd_q      <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else if (open_w) begin
      cnt_q     <= '0;
      wd_q      <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else if (state_q == COLLECT) begin
      if (rise_w) begin
        if (cnt_q != CNT_W'(N_VECTORS)) cnt_q <= cnt_q + 1'b1;
        wd_q <= '0;
      end else if (wd_expire_w) begin
        done_q    <= 1'b1;
        timeout_q <= 1'b1;
        pass_q    <= 1'b0;
      end else begin
        wd_q <= wd_q + 1'b1;
      end
    end else if (state_q == COMPARE) begin
      pass_q <= (signature == GOLDEN_SIG);
      done_q <= 1'b1;
    end
  end

  misr16 #(
    .SEED (SEED),
    .POLY (POLY)
  ) u_misr (
    .clk    (clk),
    .reset  (reset),
    .load_i (open_w),
    .en_i   (accept_w),
    .din_i  (mul_if.result),
    .sig_o  (signature)
  );

  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign vec_count = cnt_q;

endmodule
